// File: rtl/rbcp_reg_responder_if.sv
// RBCP link between the SiTCP core (master) and a register responder (slave).
interface rbcp_if;
    logic        RBCP_ACT;
    logic [31:0] RBCP_ADDR;
    logic        RBCP_WE;
    logic        RBCP_RE;
    logic [7:0]  RBCP_WD;
    logic        RBCP_ACK;
    logic [7:0]  RBCP_RD;

    modport master (
        output RBCP_ACT, RBCP_ADDR, RBCP_WE, RBCP_RE, RBCP_WD,
        input  RBCP_ACK, RBCP_RD
    );

    modport slave (
        input  RBCP_ACT, RBCP_ADDR, RBCP_WE, RBCP_RE, RBCP_WD,
        output RBCP_ACK, RBCP_RD
    );
endinterface

// File: rtl/rbcp_reg_responder.sv
// RBCP register responder: control bytes, status snapshot, version word and write pulses.
// Optional feature macro RBCP_ERR_CNT_EN adds a saturating unmapped-access counter at offset 0x3F.
module rbcp_reg_responder #(
    parameter logic [31:0]         BASE_ADDR   = 32'h0000_0000,
    parameter int                  N_CTRL      = 8,
    parameter logic [8*N_CTRL-1:0] CTRL_INIT   = '0,
    parameter logic [31:0]         VERSION     = 32'h0000_0001,
    parameter int                  ACK_LATENCY = 1
) (
    input  logic                CLK,
    input  logic                SYS_RSTn,
    rbcp_if.slave               bus,
    output logic [8*N_CTRL-1:0] CTRL_OUT,
    output logic [7:0]          PULSE_OUT,
    input  logic [31:0]         STATUS_IN
);

    localparam logic [7:0] CTRL_LIM = 8'(N_CTRL);

    logic [7:0]  w_off;
    logic        w_hit;
    logic        w_busy;
    logic        w_accept;
    logic        w_wr;
    logic        w_rd;
    logic        w_mapped;
    logic [7:0]  w_rd_mux;

    logic [ACK_LATENCY-1:0] r_vld;
    logic [7:0]             r_rd_pipe [ACK_LATENCY];
    logic [7:0]             r_ctrl [N_CTRL];
    logic [7:0]             r_pulse;
    logic [23:0]            r_shadow;
`ifdef RBCP_ERR_CNT_EN
    logic [7:0]             r_err_cnt;
`endif

    assign w_off = bus.RBCP_ADDR[7:0];
    assign w_hit = (bus.RBCP_ADDR[31:8] == BASE_ADDR[31:8]);

    // The stage that is currently acking does not block a new strobe.
    always_comb begin
        w_busy = 1'b0;
        for (int k = 0; k < ACK_LATENCY - 1; k++) begin
            w_busy = w_busy | r_vld[k];
        end
    end

    assign w_accept = bus.RBCP_ACT & w_hit & (bus.RBCP_WE | bus.RBCP_RE) & ~w_busy;
    assign w_wr     = w_accept & bus.RBCP_WE;
    assign w_rd     = w_accept & bus.RBCP_RE & ~bus.RBCP_WE;

    always_comb begin
        w_mapped = (w_off < CTRL_LIM)
                 || (w_off >= 8'h10 && w_off <= 8'h13)
                 || (w_off == 8'h20)
                 || (w_off >= 8'h30 && w_off <= 8'h33);
`ifdef RBCP_ERR_CNT_EN
        if (w_off == 8'h3F) begin
            w_mapped = 1'b1;
        end
`endif
    end

    always_comb begin
        w_rd_mux = 8'h00;
        if (w_rd) begin
            for (int k = 0; k < N_CTRL; k++) begin
                if (w_off == 8'(k)) begin
                    w_rd_mux = r_ctrl[k];
                end
            end
            case (w_off)
                8'h10:   w_rd_mux = STATUS_IN[7:0];
                8'h11:   w_rd_mux = r_shadow[7:0];
                8'h12:   w_rd_mux = r_shadow[15:8];
                8'h13:   w_rd_mux = r_shadow[23:16];
                8'h30:   w_rd_mux = VERSION[7:0];
                8'h31:   w_rd_mux = VERSION[15:8];
                8'h32:   w_rd_mux = VERSION[23:16];
                8'h33:   w_rd_mux = VERSION[31:24];
`ifdef RBCP_ERR_CNT_EN
                8'h3F:   w_rd_mux = r_err_cnt;
`endif
                default: ;
            endcase
        end
    end

    // Ack pipeline: stage 0 holds the read data captured one cycle after the strobe.
    always_ff @(posedge CLK) begin
        if (!SYS_RSTn || !bus.RBCP_ACT) begin
            r_vld <= '0;
            for (int k = 0; k < ACK_LATENCY; k++) begin
                r_rd_pipe[k] <= 8'h00;
            end
        end else begin
            r_vld[0]     <= w_accept;
            r_rd_pipe[0] <= w_rd_mux;
            for (int k = 1; k < ACK_LATENCY; k++) begin
                r_vld[k]     <= r_vld[k-1];
                r_rd_pipe[k] <= r_rd_pipe[k-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!SYS_RSTn) begin
            for (int k = 0; k < N_CTRL; k++) begin
                r_ctrl[k] <= CTRL_INIT[8*k +: 8];
            end
            r_pulse  <= 8'h00;
            r_shadow <= 24'h0;
        end else begin
            r_pulse <= (w_wr && w_off == 8'h20) ? bus.RBCP_WD : 8'h00;
            if (w_rd && w_off == 8'h10) begin
                r_shadow <= STATUS_IN[31:8];
            end
            for (int k = 0; k < N_CTRL; k++) begin
                if (w_wr && w_off == 8'(k)) begin
                    r_ctrl[k] <= bus.RBCP_WD;
                end
            end
        end
    end

`ifdef RBCP_ERR_CNT_EN
    always_ff @(posedge CLK) begin
        if (!SYS_RSTn) begin
            r_err_cnt <= 8'h00;
        end else if (w_wr && w_off == 8'h3F) begin
            r_err_cnt <= 8'h00;
        end else if (w_accept && !w_mapped && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end
`endif

    assign bus.RBCP_ACK = r_vld[ACK_LATENCY-1];
    assign bus.RBCP_RD  = r_rd_pipe[ACK_LATENCY-1];
    assign PULSE_OUT    = r_pulse;

    for (genvar g = 0; g < N_CTRL; g++) begin : g_ctrl_out
        assign CTRL_OUT[8*g +: 8] = r_ctrl[g];
    end

endmodule

// File: tb/tb_rbcp_reg_responder.sv
// Directed table-driven bench for rbcp_reg_responder at ACK latency 1 and 3.
module tb_rbcp_reg_responder;

    logic        clk = 1'b0;
    logic        rst1_n = 1'b0;
    logic        rst3_n = 1'b0;
    logic [31:0] status = 32'h0;
    logic [63:0] ctrl1, ctrl3;
    logic [7:0]  pulse1, pulse3;
    int          n_vec = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    rbcp_if b1 ();
    rbcp_if b3 ();

    rbcp_reg_responder #(.ACK_LATENCY(1)) u_dut1 (
        .CLK(clk), .SYS_RSTn(rst1_n), .bus(b1),
        .CTRL_OUT(ctrl1), .PULSE_OUT(pulse1), .STATUS_IN(status)
    );

    rbcp_reg_responder #(.ACK_LATENCY(3), .VERSION(32'h4433_2201)) u_dut3 (
        .CLK(clk), .SYS_RSTn(rst3_n), .bus(b3),
        .CTRL_OUT(ctrl3), .PULSE_OUT(pulse3), .STATUS_IN(status)
    );

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [7:0]  wd;
        logic [31:0] st;
        logic        exp_ack;
        logic [7:0]  exp_rd;
        logic [63:0] exp_ctrl;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic access1(input logic we, input logic re, input logic [31:0] addr, input logic [7:0] wd,
                           output logic ack, output logic [7:0] rd, output logic [7:0] pls);
        @(negedge clk);
        b1.RBCP_WE = we; b1.RBCP_RE = re; b1.RBCP_ADDR = addr; b1.RBCP_WD = wd;
        @(negedge clk);
        b1.RBCP_WE = 1'b0; b1.RBCP_RE = 1'b0;
        ack = b1.RBCP_ACK; rd = b1.RBCP_RD; pls = pulse1;
    endtask

    task automatic run3(input logic we, input logic re, input logic [31:0] addr, input logic [7:0] wd,
                        input int rst_at, input int act_at, input logic second,
                        output int n_ack, output int first_at, output logic [7:0] rd_at);
        n_ack = 0; first_at = 0; rd_at = 8'h00;
        @(negedge clk);
        b3.RBCP_WE = we; b3.RBCP_RE = re; b3.RBCP_ADDR = addr; b3.RBCP_WD = wd;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (b3.RBCP_ACK) begin
                n_ack++;
                if (first_at == 0) begin
                    first_at = i;
                    rd_at = b3.RBCP_RD;
                end
            end
            if (i == 1) begin
                if (second) begin
                    b3.RBCP_WE = 1'b1; b3.RBCP_RE = 1'b0; b3.RBCP_ADDR = 32'h01; b3.RBCP_WD = 8'h55;
                end else begin
                    b3.RBCP_WE = 1'b0; b3.RBCP_RE = 1'b0;
                end
            end
            if (i == 2) begin
                b3.RBCP_WE = 1'b0; b3.RBCP_RE = 1'b0;
            end
            if (i == rst_at) rst3_n = 1'b0;
            if (i == rst_at + 1) rst3_n = 1'b1;
            if (i == act_at) b3.RBCP_ACT = 1'b0;
            if (i == act_at + 1) b3.RBCP_ACT = 1'b1;
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd, pls;
        int         na, fa;
        logic [7:0] ra;
        int         acks;

        b1.RBCP_ACT = 1'b1; b1.RBCP_WE = 1'b0; b1.RBCP_RE = 1'b0; b1.RBCP_ADDR = '0; b1.RBCP_WD = '0;
        b3.RBCP_ACT = 1'b1; b3.RBCP_WE = 1'b0; b3.RBCP_RE = 1'b0; b3.RBCP_ADDR = '0; b3.RBCP_WD = '0;

        tbl[0]  = '{1'b1, 1'b0, 32'h002, 8'h5A, 32'h0,         1'b1, 8'h00, 64'h0000_0000_005A_0000};
        tbl[1]  = '{1'b0, 1'b1, 32'h002, 8'h00, 32'h0,         1'b1, 8'h5A, 64'h0000_0000_005A_0000};
        tbl[2]  = '{1'b0, 1'b1, 32'h010, 8'h00, 32'h11223344,  1'b1, 8'h44, 64'h0000_0000_005A_0000};
        tbl[3]  = '{1'b0, 1'b1, 32'h013, 8'h00, 32'hAABBCCDD,  1'b1, 8'h11, 64'h0000_0000_005A_0000};
        tbl[4]  = '{1'b0, 1'b1, 32'h011, 8'h00, 32'hAABBCCDD,  1'b1, 8'h33, 64'h0000_0000_005A_0000};
        tbl[5]  = '{1'b0, 1'b1, 32'h010, 8'h00, 32'hAABBCCDD,  1'b1, 8'hDD, 64'h0000_0000_005A_0000};
        tbl[6]  = '{1'b0, 1'b1, 32'h012, 8'h00, 32'hAABBCCDD,  1'b1, 8'hBB, 64'h0000_0000_005A_0000};
        tbl[7]  = '{1'b0, 1'b1, 32'h030, 8'h00, 32'hAABBCCDD,  1'b1, 8'h01, 64'h0000_0000_005A_0000};
        tbl[8]  = '{1'b0, 1'b1, 32'h031, 8'h00, 32'hAABBCCDD,  1'b1, 8'h00, 64'h0000_0000_005A_0000};
        tbl[9]  = '{1'b0, 1'b1, 32'h033, 8'h00, 32'hAABBCCDD,  1'b1, 8'h00, 64'h0000_0000_005A_0000};
        tbl[10] = '{1'b1, 1'b0, 32'h030, 8'hFF, 32'hAABBCCDD,  1'b1, 8'h00, 64'h0000_0000_005A_0000};
        tbl[11] = '{1'b0, 1'b1, 32'h030, 8'h00, 32'hAABBCCDD,  1'b1, 8'h01, 64'h0000_0000_005A_0000};
        tbl[12] = '{1'b0, 1'b1, 32'h020, 8'h00, 32'hAABBCCDD,  1'b1, 8'h00, 64'h0000_0000_005A_0000};
        tbl[13] = '{1'b0, 1'b1, 32'h025, 8'h00, 32'hAABBCCDD,  1'b1, 8'h00, 64'h0000_0000_005A_0000};
        tbl[14] = '{1'b1, 1'b0, 32'h007, 8'hC3, 32'hAABBCCDD,  1'b1, 8'h00, 64'hC300_0000_005A_0000};
        tbl[15] = '{1'b0, 1'b1, 32'h007, 8'h00, 32'hAABBCCDD,  1'b1, 8'hC3, 64'hC300_0000_005A_0000};
        tbl[16] = '{1'b1, 1'b0, 32'h008, 8'h77, 32'hAABBCCDD,  1'b1, 8'h00, 64'hC300_0000_005A_0000};
        tbl[17] = '{1'b0, 1'b1, 32'h008, 8'h00, 32'hAABBCCDD,  1'b1, 8'h00, 64'hC300_0000_005A_0000};
        tbl[18] = '{1'b1, 1'b1, 32'h002, 8'hA5, 32'hAABBCCDD,  1'b1, 8'h00, 64'hC300_0000_00A5_0000};
        tbl[19] = '{1'b0, 1'b1, 32'h002, 8'h00, 32'hAABBCCDD,  1'b1, 8'hA5, 64'hC300_0000_00A5_0000};
        tbl[20] = '{1'b1, 1'b0, 32'h102, 8'hEE, 32'hAABBCCDD,  1'b0, 8'h00, 64'hC300_0000_00A5_0000};
        tbl[21] = '{1'b0, 1'b1, 32'h100, 8'h00, 32'hAABBCCDD,  1'b0, 8'h00, 64'hC300_0000_00A5_0000};

        repeat (3) @(negedge clk);
        rst1_n = 1'b1; rst3_n = 1'b1;
        @(negedge clk);
        chk("rst_ack",   {63'h0, b1.RBCP_ACK}, 64'h0);
        chk("rst_rd",    {56'h0, b1.RBCP_RD}, 64'h0);
        chk("rst_ctrl",  ctrl1, 64'h0);
        chk("rst_pulse", {56'h0, pulse1}, 64'h0);
        chk("rst_ctrl3", ctrl3, 64'h0);

        for (int i = 0; i < 22; i++) begin
            status = tbl[i].st;
            access1(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wd, ack, rd, pls);
            chk($sformatf("vec%0d_ack", i), {63'h0, ack}, {63'h0, tbl[i].exp_ack});
            chk($sformatf("vec%0d_rd", i), {56'h0, rd}, {56'h0, tbl[i].exp_rd});
            chk($sformatf("vec%0d_ctrl", i), ctrl1, tbl[i].exp_ctrl);
        end

        // Pulse register lasts exactly one cycle, also when RE rides along with WE.
        access1(1'b1, 1'b0, 32'h020, 8'h81, ack, rd, pls);
        chk("pulse_we_on", {56'h0, pls}, 64'h81);
        chk("pulse_we_ack", {63'h0, ack}, 64'h1);
        @(negedge clk);
        chk("pulse_we_off", {56'h0, pulse1}, 64'h0);
        chk("ack_one_cycle", {63'h0, b1.RBCP_ACK}, 64'h0);
        access1(1'b1, 1'b1, 32'h020, 8'h81, ack, rd, pls);
        chk("pulse_wr_on", {56'h0, pls}, 64'h81);
        chk("pulse_wr_rd", {56'h0, rd}, 64'h0);
        @(negedge clk);
        chk("pulse_wr_off", {56'h0, pulse1}, 64'h0);

        // Out-of-window read: silent for eight cycles.
        @(negedge clk);
        b1.RBCP_RE = 1'b1; b1.RBCP_ADDR = 32'h100;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b1.RBCP_RE = 1'b0;
            if (b1.RBCP_ACK || b1.RBCP_RD != 8'h00) acks++;
        end
        chk("miss_8cyc", acks, 0);
        chk("miss_ctrl", ctrl1, 64'hC300_0000_00A5_0000);

`ifdef RBCP_ERR_CNT_EN
        access1(1'b1, 1'b0, 32'h03F, 8'h12, ack, rd, pls);
        for (int i = 0; i < 3; i++) access1(1'b0, 1'b1, 32'h025, 8'h00, ack, rd, pls);
        access1(1'b0, 1'b1, 32'h03F, 8'h00, ack, rd, pls);
        chk("err_cnt_3", {56'h0, rd}, 64'h03);
        access1(1'b1, 1'b0, 32'h03F, 8'h00, ack, rd, pls);
        access1(1'b0, 1'b1, 32'h03F, 8'h00, ack, rd, pls);
        chk("err_cnt_clr", {56'h0, rd}, 64'h00);
        for (int i = 0; i < 300; i++) access1(1'b0, 1'b1, 32'h025, 8'h00, ack, rd, pls);
        access1(1'b0, 1'b1, 32'h03F, 8'h00, ack, rd, pls);
        chk("err_cnt_sat", {56'h0, rd}, 64'hFF);
`else
        access1(1'b0, 1'b1, 32'h03F, 8'h00, ack, rd, pls);
        chk("unmapped_3f_ack", {63'h0, ack}, 64'h1);
        chk("unmapped_3f_rd", {56'h0, rd}, 64'h0);
`endif

        // Latency-3 instance.
        run3(1'b1, 1'b0, 32'h001, 8'h99, 0, 0, 1'b0, na, fa, ra);
        chk("l3_wr_nack", na, 1);
        chk("l3_wr_at", fa, 3);
        chk("l3_wr_ctrl", {56'h0, ctrl3[15:8]}, 64'h99);
        run3(1'b0, 1'b1, 32'h001, 8'h00, 0, 0, 1'b0, na, fa, ra);
        chk("l3_rd_at", fa, 3);
        chk("l3_rd_data", {56'h0, ra}, 64'h99);
        run3(1'b0, 1'b1, 32'h032, 8'h00, 0, 0, 1'b0, na, fa, ra);
        chk("l3_ver2", {56'h0, ra}, 64'h33);
        run3(1'b0, 1'b1, 32'h030, 8'h00, 1, 0, 1'b0, na, fa, ra);
        chk("l3_rst_nack", na, 0);
        chk("l3_rst_ctrl", ctrl3, 64'h0);
        run3(1'b0, 1'b1, 32'h030, 8'h00, 0, 2, 1'b0, na, fa, ra);
        chk("l3_act_nack", na, 0);
        run3(1'b0, 1'b1, 32'h030, 8'h00, 0, 0, 1'b1, na, fa, ra);
        chk("l3_busy_nack", na, 1);
        chk("l3_busy_at", fa, 3);
        chk("l3_busy_rd", {56'h0, ra}, 64'h01);
        chk("l3_busy_ctrl", {56'h0, ctrl3[15:8]}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
